// File: rtl/if_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: widths, alignment,
// default reset vector and the fetch FSM state type.
package if_ctrl_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_ALIGN_MASK  = 32'hFFFF_FFFC;
   localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_BOOT = 2'd0,
      IF_REQ  = 2'd1,
      IF_WAIT = 2'd2
   } if_state_t;

   // Force a fetch target onto a 4-byte instruction boundary.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
      return addr & INST_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register with its next-PC selection: reset vector, aligned
// redirect target, +4 sequencing on an accepted fetch, or hold.
module if_pc_gen
   import if_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirectPc,
   input  logic            i_advance,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] r_pc;

   // Redirect beats sequencing; the adder wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc <= RESET_PC;
      end else if (i_redirect) begin
         r_pc <= alignPc(i_redirectPc);
      end else if (i_advance) begin
         r_pc <= r_pc + INST_BYTES;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: single-outstanding req/gnt/rvalid fetch to
// instruction memory, redirect with kill of an in-flight fetch, and a
// one-entry valid/ready register presenting instructions to decode.
module if_ctrl
   import if_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   output logic [XLEN-1:0] pc_o
);

   if_state_t       r_state;
   logic            r_kill;
   logic [XLEN-1:0] r_pendPc;
   logic            r_instValid;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_instPc;

   logic [XLEN-1:0] w_pc;
   logic            w_stalled;
   logic            w_req;
   logic            w_grant;
   logic            w_redirect;

   // Decode holding a full output register blocks new requests; a redirect
   // cycle never requests so a grant cannot collide with a new target.
   assign w_stalled  = r_instValid && !inst_ready_i;
   assign w_req      = (r_state == IF_REQ) && !w_stalled && !redirect_i;
   assign w_grant    = w_req && imem_gnt_i;
   assign w_redirect = redirect_i && (r_state != IF_BOOT);

   if_pc_gen #(
      .RESET_PC(RESET_PC)
   ) u_pcGen (
      .clk         (clk),
      .rst         (rst),
      .i_redirect  (w_redirect),
      .i_redirectPc(redirect_pc_i),
      .i_advance   (w_grant),
      .o_pc        (w_pc)
   );

   // Fetch FSM, kill tracking of a superseded fetch, and the decode register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IF_BOOT;
         r_kill      <= 1'b0;
         r_pendPc    <= '0;
         r_instValid <= 1'b0;
         r_inst      <= '0;
         r_instPc    <= '0;
      end else begin
         if (inst_ready_i) begin
            r_instValid <= 1'b0;
         end
         if (w_redirect) begin
            r_instValid <= 1'b0;
            if ((r_state == IF_WAIT) && !imem_rvalid_i) begin
               r_kill  <= 1'b1;
               r_state <= IF_WAIT;
            end else begin
               r_kill  <= 1'b0;
               r_state <= IF_REQ;
            end
         end else begin
            case (r_state)
               IF_BOOT: begin
                  r_state <= IF_REQ;
               end
               IF_REQ: begin
                  if (w_grant) begin
                     r_pendPc <= w_pc;
                     r_state  <= IF_WAIT;
                  end
               end
               IF_WAIT: begin
                  if (imem_rvalid_i) begin
                     if (r_kill) begin
                        r_kill <= 1'b0;
                     end else begin
                        r_inst      <= imem_rdata_i;
                        r_instPc    <= r_pendPc;
                        r_instValid <= 1'b1;
                     end
                     r_state <= IF_REQ;
                  end
               end
               default: begin
                  r_state <= IF_BOOT;
               end
            endcase
         end
      end
   end

   assign imem_req_o   = w_req;
   assign imem_addr_o  = w_pc;
   assign pc_o         = w_pc;
   assign inst_valid_o = r_instValid;
   assign inst_o       = r_inst;
   assign inst_pc_o    = r_instPc;

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed vector table, randomized run against a
// queue-based fetch model, and a reset-vector wrap check on a second instance.
module tb_if_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        instReady;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        instValid;
   logic [31:0] inst;
   logic [31:0] instPc;
   logic [31:0] pc;

   logic        rstWrap;
   logic        wReq;
   logic [31:0] wAddr;
   logic        wValid;
   logic [31:0] wInst;
   logic [31:0] wInstPc;
   logic [31:0] wPc;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   if_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req_o   (imemReq),
      .imem_addr_o  (imemAddr),
      .imem_gnt_i   (imemGnt),
      .imem_rvalid_i(imemRvalid),
      .imem_rdata_i (imemRdata),
      .redirect_i   (redirect),
      .redirect_pc_i(redirectPc),
      .inst_valid_o (instValid),
      .inst_ready_i (instReady),
      .inst_o       (inst),
      .inst_pc_o    (instPc),
      .pc_o         (pc)
   );

   if_ctrl #(
      .RESET_PC(32'hFFFF_FFF8)
   ) u_dutWrap (
      .clk          (clk),
      .rst          (rstWrap),
      .imem_req_o   (wReq),
      .imem_addr_o  (wAddr),
      .imem_gnt_i   (1'b1),
      .imem_rvalid_i(1'b1),
      .imem_rdata_i (32'h0),
      .redirect_i   (1'b0),
      .redirect_pc_i(32'h0),
      .inst_valid_o (wValid),
      .inst_ready_i (1'b1),
      .inst_o       (wInst),
      .inst_pc_o    (wInstPc),
      .pc_o         (wPc)
   );

   typedef struct {
      logic        rstN;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] redirPc;
      logic        ready;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expInst;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      logic [31:0] pc;
      bit          killed;
   } fetch_t;

   fetch_t      inflight[$];
   bit          mBooted;
   logic [31:0] mNextPc;
   bit          mOutValid;
   logic [31:0] mOutInst;
   logic [31:0] mOutPc;

   function automatic vec_t mk(input logic rstN, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic redir,
                               input logic [31:0] redirPc, input logic ready,
                               input logic expReq, input logic [31:0] expAddr,
                               input logic expValid, input logic [31:0] expInst,
                               input logic [31:0] expPc);
      vec_t v;
      v.rstN = rstN; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
      v.redir = redir; v.redirPc = redirPc; v.ready = ready;
      v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
      v.expInst = expInst; v.expPc = expPc;
      return v;
   endfunction

   task automatic applyStimulus(input logic rstN, input logic gnt, input logic rvalid,
                                input logic [31:0] rdata, input logic redir,
                                input logic [31:0] redirPc, input logic ready);
      rst        = rstN;
      imemGnt    = gnt;
      imemRvalid = rvalid;
      imemRdata  = rdata;
      redirect   = redir;
      redirectPc = redirPc;
      instReady  = ready;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mBooted   = 1'b0;
      mNextPc   = 32'h0;
      inflight.delete();
      mOutValid = 1'b0;
      mOutInst  = 32'h0;
      mOutPc    = 32'h0;
   endtask

   task automatic resetMain();
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic [31:0] wrapAddrs[$];
      logic [31:0] wrapExp[4];

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      rstWrap = 1'b0;

      //         rstN gnt rv  rdata          rd  rdPc           rdy  req addr          vld inst           ipc
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 1, 32'hA000_0000,0, 32'h0,        1,   0, 32'h0000_0004, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'hA000_0000,32'h0));
      vecs.push_back(mk(1, 0, 1, 32'hA000_0001,0, 32'h0,        1,   0, 32'h0000_0008, 0, 32'hA000_0000,32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'hA000_0001,32'h4));
      vecs.push_back(mk(1, 0, 1, 32'hA000_0002,0, 32'h0,        1,   0, 32'h0000_000C, 0, 32'hA000_0001,32'h4));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_000C, 1, 32'hA000_0002,32'h8));
      vecs.push_back(mk(1, 0, 1, 32'hA000_0003,0, 32'h0,        1,   0, 32'h0000_0010, 0, 32'hA000_0002,32'h8));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0010, 1, 32'hA000_0003,32'hC));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, 32'hA000_0003,32'hC));
      vecs.push_back(mk(1, 0, 1, 32'hA000_0004,0, 32'h0,        0,   0, 32'h0000_0014, 0, 32'hA000_0003,32'hC));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0014, 1, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0014, 1, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0014, 1, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0014, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0000_0103,1,   0, 32'h0000_0018, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0000_0100, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 0, 1, 32'hDEAD_0000,0, 32'h0,        1,   0, 32'h0000_0100, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0100, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 0, 1, 32'hB000_0000,0, 32'h0,        1,   0, 32'h0000_0104, 0, 32'hA000_0004,32'h10));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0104, 1, 32'hB000_0000,32'h100));
      vecs.push_back(mk(1, 0, 1, 32'hDEAD_0002,1, 32'h0000_0200,1,   0, 32'h0000_0108, 0, 32'hB000_0000,32'h100));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0200, 0, 32'hB000_0000,32'h100));
      vecs.push_back(mk(1, 0, 1, 32'hC000_0000,0, 32'h0,        1,   0, 32'h0000_0204, 0, 32'hB000_0000,32'h100));
      vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0000_0300,0,   0, 32'h0000_0204, 1, 32'hC000_0000,32'h200));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0300, 0, 32'hC000_0000,32'h200));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'hC000_0000,32'h200));
      vecs.push_back(mk(1, 1, 1, 32'hEEEE_EEEE,1, 32'h0000_0500,1,   0, 32'h0000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 1, 32'hEEEE_EEEE,0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h0000_1234,0, 32'h0,        1,   0, 32'h0000_0004, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'h0000_1234,32'h0));

      resetMain();
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rstN, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
                       vecs[i].redir, vecs[i].redirPc, vecs[i].ready);
         #1;
         checkOutput($sformatf("vec%0d req", i),   {31'h0, imemReq},   {31'h0, vecs[i].expReq});
         checkOutput($sformatf("vec%0d addr", i),  imemAddr,           vecs[i].expAddr);
         checkOutput($sformatf("vec%0d pc", i),    pc,                 vecs[i].expAddr);
         checkOutput($sformatf("vec%0d valid", i), {31'h0, instValid}, {31'h0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d inst", i),  inst,               vecs[i].expInst);
         checkOutput($sformatf("vec%0d ipc", i),   instPc,             vecs[i].expPc);
      end

      resetMain();
      modelReset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic        rN, g, rv, rd, rdy, expReq;
         logic [31:0] data, tgt;
         fetch_t      f;
         bit          load;
         @(negedge clk);
         rN   = ($urandom_range(0, 199) != 0);
         g    = ($urandom_range(0, 9) < 6);
         rv   = (inflight.size() > 0) && ($urandom_range(0, 1) == 1);
         data = $urandom;
         rd   = ($urandom_range(0, 11) == 0);
         tgt  = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         rdy  = ($urandom_range(0, 9) < 7);
         applyStimulus(rN, g, rv, data, rd, tgt, rdy);
         #1;
         expReq = mBooted && (inflight.size() == 0) && !(mOutValid && !rdy) && !rd;
         checkOutput($sformatf("rnd%0d req", cyc),   {31'h0, imemReq},   {31'h0, expReq});
         checkOutput($sformatf("rnd%0d addr", cyc),  imemAddr,           mNextPc);
         checkOutput($sformatf("rnd%0d pc", cyc),    pc,                 mNextPc);
         checkOutput($sformatf("rnd%0d valid", cyc), {31'h0, instValid}, {31'h0, mOutValid});
         checkOutput($sformatf("rnd%0d inst", cyc),  inst,               mOutInst);
         checkOutput($sformatf("rnd%0d ipc", cyc),   instPc,             mOutPc);

         if (!rN) begin
            modelReset();
         end else if (!mBooted) begin
            mBooted = 1'b1;
         end else if (rd) begin
            mNextPc   = tgt & 32'hFFFF_FFFC;
            mOutValid = 1'b0;
            if (inflight.size() > 0) begin
               if (rv) begin
                  void'(inflight.pop_front());
               end else begin
                  inflight[0].killed = 1'b1;
               end
            end
         end else begin
            load = 1'b0;
            if (rv && (inflight.size() > 0)) begin
               f = inflight.pop_front();
               load = !f.killed;
            end else if (expReq && g) begin
               f.pc = mNextPc;
               f.killed = 1'b0;
               inflight.push_back(f);
               mNextPc = mNextPc + 32'd4;
            end
            if (load) begin
               mOutValid = 1'b1;
               mOutInst  = data;
               mOutPc    = f.pc;
            end else if (rdy) begin
               mOutValid = 1'b0;
            end
         end
      end

      wrapExp[0] = 32'hFFFF_FFF8;
      wrapExp[1] = 32'hFFFF_FFFC;
      wrapExp[2] = 32'h0000_0000;
      wrapExp[3] = 32'h0000_0004;
      @(negedge clk);
      checkOutput("wrap reset pc", wPc, 32'hFFFF_FFF8);
      checkOutput("wrap reset req", {31'h0, wReq}, 32'h0);
      rstWrap = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (wReq) begin
            wrapAddrs.push_back(wAddr);
         end
      end
      checkOutput("wrap fetch count", 32'(wrapAddrs.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wrapAddrs.size()) begin
            checkOutput($sformatf("wrap fetch%0d", i), wrapAddrs[i], wrapExp[i]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
